load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Connects a single-issue core to a simple request/grant/rvalid
//            data bus. It handles byte, half and word loads and stores. It
//            generates byte enables and lane-replicated store data. It formats
//            load data with sign or zero extension. It reports a bus error
//            when an access times out.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH     : core/bus data width (only 32 is supported)
//   TIMEOUT_CYCLES : maximum cycles spent in REQ+WAIT before a bus error
// Configuration macro
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses fault
//                          without a bus access; when undefined, the
//                          misaligned low address bits are forced to zero
// Ports
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   req_i, we_i, size_i,
//   unsigned_i, addr_i, wdata_i    : core access request (held until done_o)
//   rdata_o, done_o, stall_o, err_o: core-side results and pipeline stall
//   bus_req_o, bus_we_o, bus_addr_o,
//   bus_be_o, bus_wdata_o          : bus request channel (registered)
//   bus_gnt_i, bus_rvalid_i,
//   bus_rdata_i                    : bus grant and response
// ============================================================================
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o,
    output logic                  stall_o,
    output logic                  err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [31:0]           bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

    localparam int          CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [1:0]         off_q;
    logic [31:0]        rdata_q;
    logic               done_q;
    logic               err_q;
    logic               bus_req_q;
    logic               bus_we_q;
    logic [31:0]        bus_addr_q;
    logic [3:0]         bus_be_q;
    logic [31:0]        bus_wdata_q;

    // ------------------------------------------------------------------------
    // Request decode. It is evaluated on the raw core inputs and only used on
    // the IDLE acceptance edge.
    // ------------------------------------------------------------------------
    logic [31:0] w_addr_eff;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_fault;

    // Misaligned low bits are dropped so that the byte-enable and
    // load-shift logic only ever sees naturally aligned offsets.
    always_comb begin
        w_addr_eff = addr_i;
        case (size_i)
            SZ_HALF: w_addr_eff = {addr_i[31:1], 1'b0};
            SZ_WORD: w_addr_eff = {addr_i[31:2], 2'b00};
            default: w_addr_eff = addr_i;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((size_i == SZ_HALF) && addr_i[0]) ||
                        ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));
    assign w_fault    = (size_i == 2'b11) || w_misalign;
`else
    assign w_fault    = (size_i == 2'b11);
`endif

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_addr_eff[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << {w_addr_eff[1], 1'b0};
                w_wdata = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                w_be    = 4'b1111;
                w_wdata = wdata_i;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = wdata_i;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load formatting. It brings the addressed lane down to bit 0 and then
    // extends it to the full width.
    // ------------------------------------------------------------------------
    logic [31:0] w_shifted;
    logic [31:0] ld_data_d;

    assign w_shifted = bus_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_data_d = w_shifted;
        case (size_q)
            SZ_BYTE: ld_data_d = uns_q ? {24'd0, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: ld_data_d = uns_q ? {16'd0, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: ld_data_d = w_shifted;
        endcase
    end

    // The timeout fires on the last allowed REQ/WAIT cycle. A grant or rvalid
    // that arrives in that same cycle still wins.
    logic w_timeout;
    assign w_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        we_q   <= we_i;
                        size_q <= size_i;
                        uns_q  <= unsigned_i;
                        off_q  <= w_addr_eff[1:0];
                        if (w_fault) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            if (!we_i) begin
                                rdata_q <= '0;
                            end
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= we_i;
                            bus_addr_q  <= {w_addr_eff[31:2], 2'b00};
                            bus_be_q    <= w_be;
                            bus_wdata_q <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus_gnt_i) begin
                        state_q   <= S_WAIT;
                        bus_req_q <= 1'b0;
                    end else if (w_timeout) begin
                        state_q   <= S_DONE;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus_rvalid_i) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= ld_data_d;
                        end
                    end else if (w_timeout) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign stall_o     = req_i & ~done_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit. The expected
//            values are computed by hand from the access address, the size
//            and the bus data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o;
    logic        done_o, stall_o, err_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .we_i         (we_i),
        .size_i       (size_i),
        .unsigned_i   (unsigned_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .stall_o      (stall_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observations captured by run_access
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_err, saw_req, stall_ok, err_after;
    int          done_cyc;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // The caller is 1 ns after a rising edge. This is cycle 0. The task
    // presents the request, drives gnt/rvalid in the chosen cycles (-1 means
    // never) and records what the bus side and the core side saw.
    task automatic run_access(input logic we, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int gnt_at, input int rv_at);
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns;
        addr_i = a; wdata_i = wd; bus_rdata_i = rd;
        saw_req = 1'b0; stall_ok = 1'b1; done_cyc = -1; obs_err = 1'b0;
        obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 1'b0;
        obs_rdata = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            next_cycle();
            bus_gnt_i    = (cyc == gnt_at);
            bus_rvalid_i = (cyc == rv_at);
            if (bus_req_o) begin
                saw_req   = 1'b1;
                obs_addr  = bus_addr_o;
                obs_be    = bus_be_o;
                obs_wdata = bus_wdata_o;
                obs_we    = bus_we_o;
            end
            if (done_o) begin
                done_cyc  = cyc;
                obs_err   = err_o;
                obs_rdata = rdata_o;
                if (stall_o) stall_ok = 1'b0;
                break;
            end else if (!stall_o) begin
                stall_ok = 1'b0;
            end
        end
        next_cycle();
        req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        err_after = err_o;
        next_cycle();
    endtask

    logic saw_done;

    initial begin
        rst_ni = 1'b1;
        req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        #1 rst_ni = 1'b0;
        next_cycle();
        check_eq("rst_rdata",  rdata_o,     32'h0);
        check_eq("rst_done",   done_o,      32'h0);
        check_eq("rst_err",    err_o,       32'h0);
        check_eq("rst_busreq", bus_req_o,   32'h0);
        check_eq("rst_be",     bus_be_o,    32'h0);
        check_eq("rst_addr",   bus_addr_o,  32'h0);
        check_eq("rst_wdata",  bus_wdata_o, 32'h0);
        check_eq("rst_we",     bus_we_o,    32'h0);
        rst_ni = 1'b1;
        next_cycle();

        // LB 0x103: top lane 0x80, sign-extended, minimum latency
        run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 1, 2);
        check_eq("lb_addr",  obs_addr,  32'h100);
        check_eq("lb_be",    obs_be,    32'h8);
        check_eq("lb_we",    obs_we,    32'h0);
        check_eq("lb_done",  done_cyc,  32'd3);
        check_eq("lb_err",   obs_err,   32'h0);
        check_eq("lb_rdata", obs_rdata, 32'hFFFFFF80);

        // LBU 0x103: zero-extended
        run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 1, 2);
        check_eq("lbu_rdata", obs_rdata, 32'h00000080);

        // LH 0x102: upper half 0x80FF sign-extended
        run_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80FF1234, 1, 2);
        check_eq("lh_be",    obs_be,    32'hC);
        check_eq("lh_rdata", obs_rdata, 32'hFFFF80FF);

        // SH 0x202: replicated half, rdata_o keeps the previous load
        run_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 32'h11111111, 1, 2);
        check_eq("sh_addr",  obs_addr,  32'h200);
        check_eq("sh_be",    obs_be,    32'hC);
        check_eq("sh_wdata", obs_wdata, 32'hBEEFBEEF);
        check_eq("sh_we",    obs_we,    32'h1);
        check_eq("sh_rdata", rdata_o,   32'hFFFF80FF);

        // SB 0x001: replicated byte in lane 1
        run_access(1'b1, 2'b00, 1'b0, 32'h001, 32'h123456A5, 32'h0, 1, 2);
        check_eq("sb_addr",  obs_addr,  32'h0);
        check_eq("sb_be",    obs_be,    32'h2);
        check_eq("sb_wdata", obs_wdata, 32'hA5A5A5A5);

        // LW with delayed grant (cycle 4) and rvalid (cycle 6)
        run_access(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 4, 6);
        check_eq("lwd_done",  done_cyc,  32'd7);
        check_eq("lwd_err",   obs_err,   32'h0);
        check_eq("lwd_stall", stall_ok,  32'h1);
        check_eq("lwd_be",    obs_be,    32'hF);
        check_eq("lwd_rdata", obs_rdata, 32'hDEADBEEF);

        // LW timeout: granted but no rvalid ever
        run_access(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h55555555, 1, -1);
        check_eq("to_done",     done_cyc,  32'd17);
        check_eq("to_err",      obs_err,   32'h1);
        check_eq("to_rdata",    obs_rdata, 32'h0);
        check_eq("to_err_held", err_after, 32'h0);

        // LHU 0x002: upper half zero-extended
        run_access(1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 32'h80FF1234, 1, 2);
        check_eq("lhu_rdata", obs_rdata, 32'h000080FF);

        // Reserved size: immediate fault with no bus access, and the load
        // result is cleared
        run_access(1'b0, 2'b11, 1'b0, 32'h030, 32'h0, 32'h12345678, 1, 2);
        check_eq("rsv_done",  done_cyc,  32'd1);
        check_eq("rsv_err",   obs_err,   32'h1);
        check_eq("rsv_noreq", saw_req,   32'h0);
        check_eq("rsv_rdata", obs_rdata, 32'h0);

        // Misaligned LW 0x101
        run_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D, 1, 2);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("mis_done",  done_cyc,  32'd1);
        check_eq("mis_err",   obs_err,   32'h1);
        check_eq("mis_noreq", saw_req,   32'h0);
`else
        check_eq("mis_addr",  obs_addr,  32'h100);
        check_eq("mis_be",    obs_be,    32'hF);
        check_eq("mis_done",  done_cyc,  32'd3);
        check_eq("mis_err",   obs_err,   32'h0);
        check_eq("mis_rdata", obs_rdata, 32'hCAFEF00D);
`endif

        // Reset pulsed during WAIT, followed by a stray rvalid
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; unsigned_i = 1'b0;
        addr_i = 32'h44; wdata_i = 32'h87654321; bus_rdata_i = 32'h0BADF00D;
        next_cycle();                       // cycle 1: REQ
        check_eq("rw_busreq", bus_req_o, 32'h1);
        bus_gnt_i = 1'b1;
        next_cycle();                       // cycle 2: WAIT
        bus_gnt_i = 1'b0;
        rst_ni = 1'b0;
        req_i  = 1'b0;
        #1;
        check_eq("rw_rdata",  rdata_o,     32'h0);
        check_eq("rw_addr",   bus_addr_o,  32'h0);
        check_eq("rw_be",     bus_be_o,    32'h0);
        check_eq("rw_wdata",  bus_wdata_o, 32'h0);
        check_eq("rw_we",     bus_we_o,    32'h0);
        check_eq("rw_busreq0", bus_req_o,  32'h0);
        #1 rst_ni = 1'b1;
        next_cycle();
        bus_rvalid_i = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus_rvalid_i = 1'b0;
            if (done_o || err_o) saw_done = 1'b1;
        end
        check_eq("rw_nodone", saw_done, 32'h0);
        check_eq("rw_idle_busreq", bus_req_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
